// File: rtl/shift_tx_ctrl.sv
// Parallel-in/serial-out shift sequencer: accepts a word over valid/ready and shifts it out
// one bit per (div+1) clocks, MSB- or LSB-first, with per-bit strobe and a done pulse.
//   state | meaning
//   IDLE  | waiting for a word, in_ready high, so low
//   SHIFT | serializing the captured word
module shift_tx_ctrl #(
  parameter int N     = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic             msb_first_i,
  input  logic             in_valid_i,
  input  logic [N-1:0]     in_data_i,
  output logic             in_ready_o,
  input  logic             abort_i,
  output logic             so_o,
  output logic             so_stb_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q;
  logic [N-1:0]       shreg_q;
  logic               dir_q;
  logic [DIV_W-1:0]   per_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               so_q;
  logic               done_q;

  logic [N-1:0]       shreg_d;
  logic               bit_end;
  logic               last_bit;

  assign shreg_d  = dir_q ? (shreg_q << 1) : (shreg_q >> 1);
  assign bit_end  = (state_q == SHIFT) && (div_cnt_q == '0);
  assign last_bit = (bit_cnt_q == CNT_W'(N - 1));

  assign in_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q == SHIFT);
  // Strobe is suppressed in an aborted cycle, so it cannot be registered ahead of time.
  assign so_stb_o   = bit_end && !abort_i;
  assign so_o       = so_q;
  assign done_o     = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      dir_q     <= 1'b0;
      per_q     <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      so_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i && !abort_i) begin
            shreg_q   <= in_data_i;
            dir_q     <= msb_first_i;
            per_q     <= div_i;
            div_cnt_q <= div_i;
            bit_cnt_q <= '0;
            so_q      <= msb_first_i ? in_data_i[N-1] : in_data_i[0];
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort_i) begin
            state_q   <= IDLE;
            so_q      <= 1'b0;
            shreg_q   <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
          end else if (div_cnt_q == '0) begin
            if (last_bit) begin
              state_q   <= IDLE;
              done_q    <= 1'b1;
              so_q      <= 1'b0;
              shreg_q   <= '0;
              bit_cnt_q <= '0;
            end else begin
              shreg_q   <= shreg_d;
              so_q      <= dir_q ? shreg_d[N-1] : shreg_d[0];
              div_cnt_q <= per_q;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            div_cnt_q <= div_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Self-checking bench for shift_tx_ctrl: each cycle of a frame is compared against the
// bit/strobe/done timeline derived arithmetically from data, order and bit period.
module tb_shift_tx_ctrl;
  localparam int N     = 8;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [DIV_W-1:0] div_i = '0;
  logic             msb_first_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic [N-1:0]     in_data_i = '0;
  logic             abort_i = 1'b0;
  logic             in_ready_o, so_o, so_stb_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_tx_ctrl #(.N(N), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n), .div_i(div_i), .msb_first_i(msb_first_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .abort_i(abort_i), .so_o(so_o), .so_stb_o(so_stb_o), .busy_o(busy_o), .done_o(done_o)
  );

  // Called right after the accept edge. Walks the frame cycle by cycle up to and including
  // the done cycle (or the cycle after an abort). abort_c=0 means no abort.
  task automatic run_frame(input logic [N-1:0] data, input logic msb, input int dv,
                           input int abort_c, input bit scramble, input bit keep_valid);
    int len;
    int last;
    len  = N * (dv + 1);
    last = (abort_c > 0) ? abort_c + 1 : len + 1;
    for (int c = 1; c <= last; c++) begin
      logic e_so, e_stb, e_busy, e_done;
      int k, idx;
      if (c > 1) @(posedge clk);
      #1;
      if (c == 1 && !keep_valid) in_valid_i = 1'b0;
      abort_i = (c == abort_c);
      if (scramble) begin
        div_i       = DIV_W'($urandom);
        msb_first_i = 1'($urandom);
      end
      @(negedge clk);
      if (c <= len && !(abort_c > 0 && c > abort_c)) begin
        k      = (c - 1) / (dv + 1);
        idx    = msb ? (N - 1 - k) : k;
        e_so   = data[idx];
        e_stb  = ((c % (dv + 1)) == 0) && (c != abort_c);
        e_busy = 1'b1;
        e_done = 1'b0;
      end else begin
        e_so   = 1'b0;
        e_stb  = 1'b0;
        e_busy = 1'b0;
        e_done = (abort_c == 0);
      end
      total++;
      if (so_o !== e_so) begin
        bad++; $display("FAIL so cycle=%0d data=%h got=%b want=%b", c, data, so_o, e_so);
      end
      total++;
      if (so_stb_o !== e_stb) begin
        bad++; $display("FAIL so_stb cycle=%0d got=%b want=%b", c, so_stb_o, e_stb);
      end
      total++;
      if (busy_o !== e_busy) begin
        bad++; $display("FAIL busy cycle=%0d got=%b want=%b", c, busy_o, e_busy);
      end
      total++;
      if (done_o !== e_done) begin
        bad++; $display("FAIL done cycle=%0d got=%b want=%b", c, done_o, e_done);
      end
      total++;
      if (in_ready_o !== !e_busy) begin
        bad++; $display("FAIL in_ready cycle=%0d got=%b want=%b", c, in_ready_o, !e_busy);
      end
    end
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] d;
    reset_n = 1'b0; in_valid_i = 1'b1; in_data_i = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b1 || so_o !== 1'b0 || so_stb_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL in_reset busy=%b ready=%b so=%b stb=%b done=%b want 0,1,0,0,0",
                      busy_o, in_ready_o, so_o, so_stb_o, done_o);
    end
    in_valid_i = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL post_reset_idle busy=%b want 0", busy_o); end
    in_data_i = 8'hFF; msb_first_i = 1'b1; div_i = 8'd2; in_valid_i = 1'b1;
    @(posedge clk); #1 in_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (so_o !== 1'b0 || busy_o !== 1'b0 || so_stb_o !== 1'b0 || done_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++; $display("FAIL midframe_reset so=%b busy=%b stb=%b done=%b ready=%b want 0,0,0,0,1",
                      so_o, busy_o, so_stb_o, done_o, in_ready_o);
    end
    @(negedge clk) reset_n = 1'b1;
    d = N'($urandom);
    in_data_i = d; msb_first_i = 1'b0; div_i = 8'd1; in_valid_i = 1'b1;
    @(posedge clk);
    run_frame(d, 1'b0, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_lsb_div0();
    in_data_i = 8'hA5; msb_first_i = 1'b0; div_i = 8'd0; in_valid_i = 1'b1;
    @(posedge clk);
    run_frame(8'hA5, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_msb_div3();
    in_data_i = 8'hC3; msb_first_i = 1'b1; div_i = 8'd3; in_valid_i = 1'b1;
    @(posedge clk);
    run_frame(8'hC3, 1'b1, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] d;
    int dv;
    logic m;
    in_data_i = 8'hFF; msb_first_i = 1'b1; div_i = 8'd1; in_valid_i = 1'b1;
    @(posedge clk);
    run_frame(8'hFF, 1'b1, 1, 0, 1'b0, 1'b1);
    in_data_i = 8'h00; msb_first_i = 1'b0; div_i = 8'd0;
    @(posedge clk);
    run_frame(8'h00, 1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      d = N'($urandom); dv = $urandom_range(0, 3); m = 1'($urandom);
      in_data_i = d; msb_first_i = m; div_i = DIV_W'(dv);
      @(posedge clk);
      run_frame(d, m, dv, 0, 1'b0, (i != 3));
    end
  endtask

  task automatic test_midframe_change();
    logic [N-1:0] d;
    int dv;
    logic m;
    for (int i = 0; i < 3; i++) begin
      d = N'($urandom); dv = $urandom_range(0, 4); m = 1'($urandom);
      in_data_i = d; msb_first_i = m; div_i = DIV_W'(dv); in_valid_i = 1'b1;
      @(posedge clk);
      run_frame(d, m, dv, 0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_abort();
    logic [N-1:0] d;
    int dv;
    logic m;
    dv = 2; d = 8'h96;
    in_data_i = d; msb_first_i = 1'b1; div_i = DIV_W'(dv); in_valid_i = 1'b1;
    @(posedge clk);
    run_frame(d, 1'b1, dv, N * (dv + 1), 1'b0, 1'b0);
    d = N'($urandom); dv = $urandom_range(0, 3); m = 1'($urandom);
    in_data_i = d; msb_first_i = m; div_i = DIV_W'(dv); in_valid_i = 1'b1;
    @(posedge clk);
    run_frame(d, m, dv, $urandom_range(1, N * (dv + 1)), 1'b0, 1'b0);
    d = N'($urandom); m = 1'($urandom);
    in_data_i = d; msb_first_i = m; div_i = 8'd1; in_valid_i = 1'b1;
    @(posedge clk);
    run_frame(d, m, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_abort();
    @(negedge clk);
    in_data_i = 8'h3C; in_valid_i = 1'b1; abort_i = 1'b1;
    #1;
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL idle_abort_ready got=%b want=1", in_ready_o); end
    @(posedge clk); #1 abort_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || so_o !== 1'b0) begin
      bad++; $display("FAIL idle_abort_capture busy=%b so=%b want 0,0", busy_o, so_o);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    int dv;
    logic m;
    for (int i = 0; i < 20; i++) begin
      d = N'($urandom); dv = $urandom_range(0, 7); m = 1'($urandom);
      in_data_i = d; msb_first_i = m; div_i = DIV_W'(dv); in_valid_i = 1'b1;
      @(posedge clk);
      run_frame(d, m, dv, 0, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_div_max();
    in_data_i = 8'h81; msb_first_i = 1'b0; div_i = 8'hFF; in_valid_i = 1'b1;
    @(posedge clk);
    run_frame(8'h81, 1'b0, 255, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lsb_div0();
    test_msb_div3();
    test_back_to_back();
    test_midframe_change();
    test_abort();
    test_idle_abort();
    test_random();
    test_div_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
